// File: rtl/l2_port_scheduler_pkg.sv
// Shared configuration and types for the L2 port scheduler.
//   L2_NUM_PORTS / L2_SUB_ID_W : default requester count and sub-id width
//   L2_PORT_IDX_W              : port index field width in a write-route entry (up to 16 ports)
//   l2_wr_route_t              : pending write burst {port, words remaining - 1}
//   l2_words_m1()              : data words minus one for a data-carrying request
package l2_port_scheduler_pkg;

    localparam int L2_NUM_PORTS  = 2;
    localparam int L2_SUB_ID_W   = 4;
    localparam int L2_PORT_IDX_W = 4;

    typedef struct packed {
        logic [L2_PORT_IDX_W-1:0] port;
        logic [4:0]               remaining;
    } l2_wr_route_t;

    // AMO stores carry exactly one word; plain writes carry amo_burst+1 words.
    function automatic logic [4:0] l2_words_m1(input logic is_amo, input logic [4:0] amo_burst);
        return is_amo ? 5'd0 : amo_burst;
    endfunction

endpackage

// File: rtl/l2_port_scheduler_if.sv
// Request, write-data and memory-side signals of the L2 port scheduler.
//   master : scheduler view (pops requester FIFOs, drives the memory request/write stage)
//   slave  : environment view (requester FIFOs and the L2 memory)
interface l2_port_scheduler_if
    import l2_port_scheduler_pkg::*;
#(
    parameter int NUM_PORTS = L2_NUM_PORTS,
    parameter int SUB_ID_W  = L2_SUB_ID_W
);
    localparam int ID_W = $clog2(NUM_PORTS) + SUB_ID_W;

    logic [NUM_PORTS-1:0]               req_valid;
    logic [NUM_PORTS-1:0][29:0]         req_addr;
    logic [NUM_PORTS-1:0]               req_rnw;
    logic [NUM_PORTS-1:0]               req_is_amo;
    logic [NUM_PORTS-1:0][4:0]          req_amo_burst;
    logic [NUM_PORTS-1:0][SUB_ID_W-1:0] req_sub_id;
    logic [NUM_PORTS-1:0]               req_pop;

    logic [NUM_PORTS-1:0]               wr_valid;
    logic [NUM_PORTS-1:0][31:0]         wr_data;
    logic [NUM_PORTS-1:0][3:0]          wr_be;
    logic [NUM_PORTS-1:0]               wr_pop;

    logic                               mem_req_valid;
    logic [29:0]                        mem_addr;
    logic                               mem_rnw;
    logic                               mem_is_amo;
    logic [4:0]                         mem_amo_burst;
    logic [ID_W-1:0]                    mem_id;
    logic                               mem_req_pop;

    logic [31:0]                        mem_wr_data;
    logic [3:0]                         mem_wr_be;
    logic                               mem_wr_valid;
    logic                               mem_wr_read;

    modport master (
        input  req_valid, req_addr, req_rnw, req_is_amo, req_amo_burst, req_sub_id,
        input  wr_valid, wr_data, wr_be, mem_req_pop, mem_wr_read,
        output req_pop, wr_pop, mem_req_valid, mem_addr, mem_rnw, mem_is_amo,
        output mem_amo_burst, mem_id, mem_wr_data, mem_wr_be, mem_wr_valid
    );

    modport slave (
        output req_valid, req_addr, req_rnw, req_is_amo, req_amo_burst, req_sub_id,
        output wr_valid, wr_data, wr_be, mem_req_pop, mem_wr_read,
        input  req_pop, wr_pop, mem_req_valid, mem_addr, mem_rnw, mem_is_amo,
        input  mem_amo_burst, mem_id, mem_wr_data, mem_wr_be, mem_wr_valid
    );

endinterface

// File: rtl/l2_port_scheduler_rr_arbiter.sv
// Round-robin arbiter with its own priority pointer.
//   clk, rst  : clock, synchronous active-high reset (pointer -> 0)
//   req       : per-port request vector
//   advance   : grant taken this cycle; pointer moves past the winner
//   gnt       : one-hot grant (combinational)
//   gnt_idx   : encoded winner
//   gnt_any   : some request present
module l2_rr_arbiter #(
    parameter int NUM_PORTS = 2,
    localparam int PW = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [PW-1:0]        gnt_idx,
    output logic                 gnt_any
);
    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        // Scan priority distance from farthest to nearest so the nearest
        // requester at or after the pointer is the last one to win.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (req[i] && i == (int'(ptr_q) + k) % NUM_PORTS) begin
                    gnt_idx = PW'(i);
                    gnt_any = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            gnt[i] = gnt_any && gnt_idx == PW'(i);
        end
        ptr_d = ptr_q;
        if (advance && gnt_any) begin
            ptr_d = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/l2_port_scheduler.sv
// Shares one L2 request/write-data channel among NUM_PORTS requesters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester FIFOs (req_*, wr_*) on one side, L2 memory (mem_*) on the other
// Requests are granted round-robin into a one-entry registered stage. Each
// data-carrying grant queues {port, words-1} so write words are steered from
// the granted ports in grant order, independently of the request stage.
module l2_port_scheduler
    import l2_port_scheduler_pkg::*;
#(
    parameter int NUM_PORTS = L2_NUM_PORTS,
    parameter int SUB_ID_W  = L2_SUB_ID_W,
    parameter int WRQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    l2_port_scheduler_if.master bus
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int QW = $clog2(WRQ_DEPTH);

    logic [NUM_PORTS-1:0] elig, gnt;
    logic [PW-1:0]        gnt_idx;
    logic                 gnt_any, stage_free, grant_fire;

    // request stage
    logic                   mem_req_valid_q, mem_req_valid_d;
    logic [29:0]            mem_addr_q, mem_addr_d;
    logic                   mem_rnw_q, mem_rnw_d;
    logic                   mem_is_amo_q, mem_is_amo_d;
    logic [4:0]             mem_amo_burst_q, mem_amo_burst_d;
    logic [PW+SUB_ID_W-1:0] mem_id_q, mem_id_d;

    // write-route queue
    l2_wr_route_t         wrq_mem [WRQ_DEPTH];
    l2_wr_route_t         wrq_head, push_entry;
    logic [QW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [QW:0]          cnt_q, cnt_d;
    logic                 wrq_full, wrq_empty, wrq_push, wrq_pop, wr_fire;
    logic [NUM_PORTS-1:0] head_sel;

    assign wrq_full   = cnt_q == (QW+1)'(WRQ_DEPTH);
    assign wrq_empty  = cnt_q == '0;
    assign wrq_head   = wrq_mem[rd_ptr_q];
    assign stage_free = !mem_req_valid_q || bus.mem_req_pop;
    assign grant_fire = stage_free && gnt_any;

    // Writes wait on a full route queue; reads bypass so they are not blocked behind them.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            elig[i] = bus.req_valid[i] && (bus.req_rnw[i] || !wrq_full);
        end
    end

    l2_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (elig),
        .advance (grant_fire),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign bus.req_pop = grant_fire ? gnt : '0;

    always_comb begin
        mem_req_valid_d = mem_req_valid_q && !bus.mem_req_pop;
        mem_addr_d      = mem_addr_q;
        mem_rnw_d       = mem_rnw_q;
        mem_is_amo_d    = mem_is_amo_q;
        mem_amo_burst_d = mem_amo_burst_q;
        mem_id_d        = mem_id_q;
        wrq_push        = 1'b0;
        push_entry      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_fire && gnt[i]) begin
                mem_req_valid_d = 1'b1;
                mem_addr_d      = bus.req_addr[i];
                mem_rnw_d       = bus.req_rnw[i];
                mem_is_amo_d    = bus.req_is_amo[i];
                mem_amo_burst_d = bus.req_amo_burst[i];
                mem_id_d        = {PW'(i), bus.req_sub_id[i]};
                wrq_push        = !bus.req_rnw[i];
                push_entry      = '{port:      L2_PORT_IDX_W'(i),
                                    remaining: l2_words_m1(bus.req_is_amo[i], bus.req_amo_burst[i])};
            end
        end
    end

    // Write steering from the port at the head of the route queue.
    always_comb begin
        bus.mem_wr_valid = 1'b0;
        bus.mem_wr_data  = '0;
        bus.mem_wr_be    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            head_sel[i] = !wrq_empty && wrq_head.port == L2_PORT_IDX_W'(i);
            if (head_sel[i]) begin
                bus.mem_wr_valid = bus.wr_valid[i];
                bus.mem_wr_data  = bus.wr_data[i];
                bus.mem_wr_be    = bus.wr_be[i];
            end
        end
        wr_fire = bus.mem_wr_valid && bus.mem_wr_read;
        wrq_pop = wr_fire && wrq_head.remaining == 5'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            bus.wr_pop[i] = wr_fire && head_sel[i];
        end
        wr_ptr_d = wrq_push ? wr_ptr_q + QW'(1) : wr_ptr_q;
        rd_ptr_d = wrq_pop  ? rd_ptr_q + QW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + (QW+1)'(wrq_push) - (QW+1)'(wrq_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_rnw_q       <= 1'b0;
            mem_is_amo_q    <= 1'b0;
            mem_amo_burst_q <= '0;
            mem_id_q        <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            cnt_q           <= '0;
        end else begin
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            mem_rnw_q       <= mem_rnw_d;
            mem_is_amo_q    <= mem_is_amo_d;
            mem_amo_burst_q <= mem_amo_burst_d;
            mem_id_q        <= mem_id_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            cnt_q           <= cnt_d;
        end
    end

    // Entry storage needs no reset: the count defines what is live. Push never
    // targets the head entry while it is being drained (that would need a full queue).
    always_ff @(posedge clk) begin
        if (wrq_push) wrq_mem[wr_ptr_q] <= push_entry;
        if (wr_fire && !wrq_pop) wrq_mem[rd_ptr_q].remaining <= wrq_head.remaining - 5'd1;
    end

    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_rnw       = mem_rnw_q;
    assign bus.mem_is_amo    = mem_is_amo_q;
    assign bus.mem_amo_burst = mem_amo_burst_q;
    assign bus.mem_id        = mem_id_q;

endmodule

// File: tb/tb_l2_port_scheduler.sv
module tb_l2_port_scheduler;
    import l2_port_scheduler_pkg::*;

    localparam int P   = 2;
    localparam int SW  = L2_SUB_ID_W;
    localparam int D   = 4;
    localparam int IDW = 1 + SW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_port_scheduler_if #(.NUM_PORTS(P), .SUB_ID_W(SW)) bus ();

    l2_port_scheduler #(.NUM_PORTS(P), .SUB_ID_W(SW), .WRQ_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [29:0]   addr;
        logic          rnw;
        logic          amo;
        logic [4:0]    ab;
        logic [SW-1:0] sid;
    } req_t;

    typedef struct {
        int          port;
        logic [31:0] d;
        logic [3:0]  be;
    } wd_t;

    // Reference model: requester FIFOs, requests granted but not yet issued to
    // memory (per port, in order), every write word per port, and the global
    // stream of write words memory must see (grant order, burst by burst).
    req_t rq   [P][$];
    req_t sent [P][$];
    wd_t  wall [P][$];
    int   wpos [P];
    int   wasg [P];
    wd_t  exp_wr[$];
    int   wlog[$];
    int   last_gnt = P - 1;

    int req_pct = 100, wr_pct = 100, pop_pct = 100, rd_pct = 100;
    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nwords(input req_t r);
        if (r.rnw) return 0;
        if (r.amo) return 1;
        return int'(r.ab) + 1;
    endfunction

    task automatic add_req(input int p, input logic rnw, input logic amo, input logic [4:0] ab);
        req_t r;
        wd_t  w;
        r.addr = 30'($urandom);
        r.rnw  = rnw;
        r.amo  = amo;
        r.ab   = ab;
        r.sid  = SW'($urandom);
        rq[p].push_back(r);
        for (int k = 0; k < nwords(r); k++) begin
            w.port = p;
            w.d    = $urandom;
            w.be   = 4'($urandom);
            wall[p].push_back(w);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < P; i++) begin
            rq[i].delete();
            sent[i].delete();
            wall[i].delete();
            wpos[i] = 0;
            wasg[i] = 0;
        end
        exp_wr.delete();
        last_gnt = P - 1;
    endtask

    // Driver: present FIFO heads at negedge, then record the handshakes the
    // coming posedge will complete.
    always begin : drv
        req_t r;
        logic both_rd;
        @(negedge clk);
        for (int i = 0; i < P; i++) begin
            bus.req_valid[i] = rq[i].size() > 0 && $urandom_range(0, 99) < req_pct;
            if (rq[i].size() > 0) begin
                bus.req_addr[i]      = rq[i][0].addr;
                bus.req_rnw[i]       = rq[i][0].rnw;
                bus.req_is_amo[i]    = rq[i][0].amo;
                bus.req_amo_burst[i] = rq[i][0].ab;
                bus.req_sub_id[i]    = rq[i][0].sid;
            end else begin
                bus.req_addr[i]      = '0;
                bus.req_rnw[i]       = 1'b0;
                bus.req_is_amo[i]    = 1'b0;
                bus.req_amo_burst[i] = '0;
                bus.req_sub_id[i]    = '0;
            end
            bus.wr_valid[i] = wpos[i] < wall[i].size() && $urandom_range(0, 99) < wr_pct;
            if (wpos[i] < wall[i].size()) begin
                bus.wr_data[i] = wall[i][wpos[i]].d;
                bus.wr_be[i]   = wall[i][wpos[i]].be;
            end else begin
                bus.wr_data[i] = '0;
                bus.wr_be[i]   = '0;
            end
        end
        bus.mem_req_pop = $urandom_range(0, 99) < pop_pct;
        bus.mem_wr_read = $urandom_range(0, 99) < rd_pct;
        #1;
        if (!rst) begin
            both_rd = bus.req_valid[0] && bus.req_valid[1] && bus.req_rnw[0] && bus.req_rnw[1];
            for (int i = 0; i < P; i++) begin
                if (bus.req_pop[i]) begin
                    if (!bus.req_valid[i]) begin
                        chk("req_pop_without_valid", 64'(i), 64'(P));
                    end else begin
                        r = rq[i].pop_front();
                        sent[i].push_back(r);
                        for (int k = 0; k < nwords(r); k++) begin
                            exp_wr.push_back(wall[i][wasg[i]]);
                            wasg[i]++;
                        end
                        // Two always-eligible requesters: winner follows the previous grant.
                        if (both_rd) chk("rr_order", 64'(i), 64'((last_gnt + 1) % P));
                        last_gnt = i;
                    end
                end
                if (bus.wr_pop[i]) wpos[i]++;
            end
        end
    end

    // Monitor: compare whatever memory consumes against the scoreboard.
    always begin : mon
        req_t r;
        wd_t  e;
        int   p;
        @(negedge clk);
        #2;
        if (!rst) begin
            if (bus.mem_req_valid && bus.mem_req_pop) begin
                p = int'(bus.mem_id[IDW-1]);
                if (sent[p].size() == 0) begin
                    chk("mem_req_unexpected_port", 64'(p), 64'(P));
                end else begin
                    r = sent[p].pop_front();
                    chk("mem_addr",      64'(bus.mem_addr),      64'(r.addr));
                    chk("mem_rnw",       64'(bus.mem_rnw),       64'(r.rnw));
                    chk("mem_is_amo",    64'(bus.mem_is_amo),    64'(r.amo));
                    chk("mem_amo_burst", 64'(bus.mem_amo_burst), 64'(r.ab));
                    chk("mem_sub_id",    64'(bus.mem_id[SW-1:0]), 64'(r.sid));
                end
            end
            if (bus.mem_wr_valid && bus.mem_wr_read) begin
                if (exp_wr.size() == 0) begin
                    chk("mem_wr_unexpected", 64'(bus.mem_wr_data), 64'hdead);
                end else begin
                    e = exp_wr.pop_front();
                    chk("mem_wr_data",   64'(bus.mem_wr_data), 64'(e.d));
                    chk("mem_wr_be",     64'(bus.mem_wr_be),   64'(e.be));
                    chk("wr_pop_onehot", 64'(bus.wr_pop),      64'(1) << e.port);
                    wlog.push_back(e.port);
                end
            end
        end
    end

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((rq[0].size() + rq[1].size() + sent[0].size() + sent[1].size() + exp_wr.size() > 0
                || bus.mem_req_valid) && n < 2000) begin
            @(negedge clk);
            #4;
            n++;
        end
        chk({nm, "_drain_timeout"}, 64'(n >= 2000), 64'(0));
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int   g;
    logic [29:0]    cap_addr;
    logic [IDW-1:0] cap_id;

    initial begin
        clear_model();
        repeat (3) @(negedge clk);
        #3;
        chk("reset_mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
        chk("reset_mem_wr_valid",  64'(bus.mem_wr_valid),  64'(0));
        chk("reset_req_pop",       64'(bus.req_pop),       64'(0));
        chk("reset_wr_pop",        64'(bus.wr_pop),        64'(0));
        #1 rst = 1'b0;

        // Two ports with reads always pending: grants alternate from port 0.
        for (int k = 0; k < 4; k++) begin
            add_req(0, 1'b1, 1'b0, 5'd0);
            add_req(1, 1'b1, 1'b0, 5'd0);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #3;
            chk("alt_req_pop", 64'(bus.req_pop), (c % 2 == 0) ? 64'b01 : 64'b10);
            if (c > 0) begin
                chk("alt_stage_valid", 64'(bus.mem_req_valid), 64'(1));
                chk("alt_id_msb", 64'(bus.mem_id[IDW-1]), (c % 2 == 0) ? 64'(1) : 64'(0));
            end
        end
        #1 wait_idle("alt");

        // Port 1 burst of 3 then port 0 burst of 1, data presented early.
        wlog.delete();
        rd_pct = 0;
        add_req(1, 1'b0, 1'b0, 5'd2);
        repeat (3) @(negedge clk);
        #4 add_req(0, 1'b0, 1'b0, 5'd0);
        repeat (3) @(negedge clk);
        #4 rd_pct = 100;
        wait_idle("wr_order");
        chk("wr_order_count", 64'(wlog.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            chk("wr_order_port", (k < wlog.size()) ? 64'(wlog[k]) : 64'hff, (k < 3) ? 64'(1) : 64'(0));
        end

        // Route queue full: reads still granted, further writes held.
        rd_pct = 0;
        for (int k = 0; k < D; k++) add_req(0, 1'b0, 1'b0, 5'd0);
        repeat (D + 2) @(negedge clk);
        #4;
        chk("wrq_fill_granted", 64'(rq[0].size()), 64'(0));
        add_req(0, 1'b0, 1'b0, 5'd0);
        add_req(1, 1'b1, 1'b0, 5'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #3;
            chk("full_write_held", 64'(bus.req_pop[0]), 64'(0));
        end
        chk("full_read_granted", 64'(rq[1].size()), 64'(0));
        chk("full_write_pending", 64'(rq[0].size()), 64'(1));
        #1 rd_pct = 100;
        wait_idle("full");

        // Memory stalls the request stage for 5 cycles.
        pop_pct = 0;
        for (int k = 0; k < 3; k++) begin
            add_req(0, 1'b1, 1'b0, 5'd0);
            add_req(1, 1'b1, 1'b0, 5'd0);
        end
        repeat (2) @(negedge clk);
        #3;
        cap_addr = bus.mem_addr;
        cap_id   = bus.mem_id;
        g        = int'(bus.mem_id[IDW-1]);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #3;
            chk("stall_valid",   64'(bus.mem_req_valid), 64'(1));
            chk("stall_addr",    64'(bus.mem_addr),      64'(cap_addr));
            chk("stall_id",      64'(bus.mem_id),        64'(cap_id));
            chk("stall_req_pop", 64'(bus.req_pop),       64'(0));
        end
        pop_pct = 100;
        @(negedge clk);
        #3;
        chk("stall_rr_resume", 64'(bus.req_pop), 64'(1) << (1 - g));
        #1 wait_idle("stall");

        // AMO store carries one word regardless of amo_burst; LR carries none.
        wlog.delete();
        add_req(0, 1'b0, 1'b1, 5'h08);
        add_req(1, 1'b1, 1'b1, 5'h00);
        wait_idle("amo");
        chk("amo_word_count", 64'(wlog.size()), 64'(1));

        // Reset in the middle of a 4-word burst, with the RR pointer at port 1.
        rd_pct = 0;
        add_req(1, 1'b0, 1'b0, 5'd3);
        repeat (2) @(negedge clk);
        #4 add_req(0, 1'b1, 1'b0, 5'd0);
        repeat (3) @(negedge clk);
        #4 rd_pct = 100;
        @(negedge clk);
        #4 rd_pct = 0;
        @(negedge clk);
        #3;
        chk("mid_burst_words_left", 64'(bus.mem_wr_valid), 64'(1));
        #1;
        rst = 1'b1;
        clear_model();
        @(negedge clk);
        #3;
        chk("rst_mid_mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
        chk("rst_mid_mem_wr_valid",  64'(bus.mem_wr_valid),  64'(0));
        #1;
        rst = 1'b0;
        rd_pct = 100;
        add_req(0, 1'b1, 1'b0, 5'd0);
        add_req(1, 1'b1, 1'b0, 5'd0);
        @(negedge clk);
        #3;
        chk("rst_first_grant", 64'(bus.req_pop), 64'b01);
        #1 wait_idle("post_reset");

        // Randomized traffic against the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #4;
            req_pct = $urandom_range(40, 100);
            wr_pct  = $urandom_range(30, 100);
            pop_pct = $urandom_range(30, 100);
            rd_pct  = $urandom_range(30, 100);
            for (int p = 0; p < P; p++) begin
                if (rq[p].size() < 4 && $urandom_range(0, 3) == 0) begin
                    add_req(p, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                            ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7)));
                end
            end
        end
        req_pct = 100;
        wr_pct  = 100;
        pop_pct = 100;
        rd_pct  = 100;
        wait_idle("random");
        chk("random_words_consumed", 64'(wpos[0] + wpos[1]), 64'(wall[0].size() + wall[1].size()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
